// File: rtl/sumsq_pkg.sv
// Shared definitions for the windowed sum-of-squares accumulator.
//   sq_width()       : width of an unsigned square of a signed in_width-bit sample
//   SUMSQ_LAT        : sample-to-result latency in clock cycles
//   sumsq_width_ok() : true when a WIDTH-bit accumulator cannot overflow over 2^log_n squares
package sumsq_pkg;

    localparam int unsigned SUMSQ_LAT = 3;

    // The most negative input squares to 2^(2*in_width-2), so 2*in_width-1 bits suffice.
    function automatic int unsigned sq_width(input int unsigned in_width);
        return 2 * in_width - 1;
    endfunction

    function automatic bit sumsq_width_ok(input int unsigned width,
                                          input int unsigned in_width,
                                          input int unsigned log_n);
        return (width >= sq_width(in_width) + log_n);
    endfunction

endpackage

// File: rtl/sumsq_square.sv
// Registered signed squarer: stage 1 captures the sample, stage 2 holds its unsigned square.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   clear             : drops in-flight samples (stage 1 -> 2 transfer); a sample presented
//                       with sink_valid in the same cycle is still captured into stage 1
//   sink, sink_valid  : signed input sample and its valid
//   sq, sq_valid      : unsigned square and its valid
module sumsq_square
    import sumsq_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 24,
    localparam int unsigned SqW = sq_width(IN_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic signed [IN_WIDTH-1:0] sink,
    input  logic                       sink_valid,
    output logic        [SqW-1:0]      sq,
    output logic                       sq_valid
);

    logic signed [IN_WIDTH-1:0]   s1_data;
    logic                         s1_valid;
    logic signed [2*IN_WIDTH-1:0] prod;
    logic                         unused_prod_msb;

    assign prod = s1_data * s1_data;
    // A square is never negative and fits in SqW bits, so the top product bit is always zero.
    assign unused_prod_msb = prod[2*IN_WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            sq       <= '0;
            sq_valid <= 1'b0;
        end else begin
            s1_data  <= sink;
            s1_valid <= sink_valid;
            sq       <= prod[SqW-1:0];
            sq_valid <= s1_valid & ~clear;
        end
    end

endmodule

// File: rtl/sumsq_acc.sv
// Windowed sum-of-squares accumulator feeding the sqrt stage.
// Squares each valid signed sample and emits one result per 2^LOG_N accepted samples.
// Build option: define SUMSQ_MEAN_EN to emit the truncated mean square (sum >> LOG_N)
// instead of the raw sum; latency is the same in both builds.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (priority over restart)
//   sink, sink_valid    : signed sample stream, accepted on every edge with sink_valid high
//   restart             : abandon the current window and start a new one
//   source              : window result (unsigned), held between updates
//   source_valid        : one-cycle pulse when source updates
module sumsq_acc
    import sumsq_pkg::*;
#(
    parameter int unsigned IN_WIDTH = 24,
    parameter int unsigned LOG_N    = 8,
    parameter int unsigned WIDTH    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IN_WIDTH-1:0] sink,
    input  logic                       sink_valid,
    input  logic                       restart,
    output logic        [WIDTH-1:0]    source,
    output logic                       source_valid
);

    localparam int unsigned SqW  = sq_width(IN_WIDTH);
    localparam int unsigned CntW = (LOG_N > 0) ? LOG_N : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((32'd1 << LOG_N) - 32'd1);

    if (!sumsq_width_ok(WIDTH, IN_WIDTH, LOG_N)) begin : g_width_err
        $error("sumsq_acc: WIDTH must be at least SQ_WIDTH + LOG_N");
    end
    if (LOG_N > 16) begin : g_log_n_err
        $error("sumsq_acc: LOG_N must be in 0..16");
    end

    logic [SqW-1:0]   sq;
    logic             sq_valid;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;
    logic [CntW-1:0]  cnt;
    logic             last;

    sumsq_square #(
        .IN_WIDTH (IN_WIDTH)
    ) u_square (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (restart),
        .sink       (sink),
        .sink_valid (sink_valid),
        .sq         (sq),
        .sq_valid   (sq_valid)
    );

    assign sum  = acc + WIDTH'(sq);
    // With LOG_N = 0 cnt stays at 0, so every valid square closes its own window.
    assign last = sq_valid && (cnt == CntLast);

`ifdef SUMSQ_MEAN_EN
    assign result = sum >> LOG_N;
`else
    assign result = sum;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc          <= '0;
            cnt          <= '0;
            source       <= '0;
            source_valid <= 1'b0;
        end else begin
            source_valid <= 1'b0;
            // A final square already in stage 3 completes even when restart is asserted.
            if (last) begin
                source       <= result;
                source_valid <= 1'b1;
            end
            if (restart || last) begin
                acc <= '0;
                cnt <= '0;
            end else if (sq_valid) begin
                acc <= sum;
                cnt <= cnt + CntW'(1);
            end
        end
    end

endmodule
